foo_pipe: RTL
=============

# foo_pipe

Parametrised N-stage successor to the two-stage `foo` pipeline. Each stage `k` adds the constant `1 << k` to the running value, so the final result is `x + (2^STAGES - 1)` modulo `2^WIDTH`. The block adds a full ready/valid handshake with per-stage stall and bubble collapse. It sits between a valid/ready producer and consumer as a drop-in arithmetic pipeline whose depth and width are set at elaboration.

## Interface
Parameters:
- `WIDTH`, default 32: operand and result width; legal range ≥ 2.
- `STAGES`, default 2: number of register stages, which is also the latency; legal range 1..`WIDTH`.

Ports:
- `clk` — in, 1: sole clock; all state is updated on its rising edge.
- `rst` — in, 1: asynchronous, active-high reset.
- `x` — in, `WIDTH`: operand; sampled when `input_valid & input_ready`.
- `input_valid` — in, 1: producer has a valid `x`.
- `input_ready` — out, 1: stage 0 can accept this cycle.
- `out` — out, `WIDTH`: result from the last stage register.
- `output_valid` — out, 1: `out` holds a valid result.
- `output_ready` — in, 1: consumer accepts `out` this cycle.

## Operation
- Per-stage state: `v[k]` (valid) and `d[k]` (`WIDTH`-bit data), for k = 0..`STAGES`-1.
- Stage function: `f_k(y) = y + (1 << k)`, truncated to `WIDTH` bits with the carry-out dropped.
  - Implement as an add of 1 on `y[WIDTH-1:k]` concatenated with the untouched `y[k-1:0]`.
- Advance condition:
  - `adv[STAGES-1] = output_ready | ~v[STAGES-1]`.
  - `adv[k] = adv[k+1] | ~v[k]` for lower stages.
- `input_ready = adv[0]`.
- Stage 0 update, when `adv[0]`:
  - `v[0] <= input_valid`.
  - If `input_valid`, `d[0] <= f_0(x)`.
- Stage k (k ≥ 1) update, when `adv[k]`:
  - `v[k] <= v[k-1]`.
  - If `v[k-1]`, `d[k] <= f_k(d[k-1])`.
- A stage that does not advance holds both `v` and `d`.
- Data registers load only when the incoming valid is 1. A bubble never overwrites data.
- Bubble collapse: an empty stage always accepts, even while a downstream stage is stalled.
- Ordering is strictly FIFO. No transaction is ever dropped or duplicated.
- Outputs: `out = d[STAGES-1]`, `output_valid = v[STAGES-1]`.
- Reset: all `v[k]` clear to 0 immediately, independent of `clk`.
  - During reset and the cycle after: `output_valid = 0` and `input_ready = 1`.
  - Any in-flight transactions are discarded.

## Timing
- Latency is exactly `STAGES` cycles from the accepting edge to `output_valid` when there is no backpressure.
- Throughput is one transaction per cycle while `output_ready` is held at 1.
- `input_ready` depends combinationally on `output_ready` through the `adv` chain. This is the only combinational in-to-out path.
- `out` and `output_valid` are pure register outputs.
- Handshake rules:
  - `out` must stay stable while `output_valid & ~output_ready`.
  - The producer may drop `input_valid` at any time. Nothing is captured unless `input_valid & input_ready` at the edge.
- Simultaneous events: a full pipeline with `output_ready = 1` accepts a new input in the same cycle (`input_ready = 1`).
- Capacity: at most `STAGES` transactions are held. With all stages valid and `output_ready = 0`, `input_ready = 0`.
- Wrap-around: results are taken mod `2^WIDTH` with no saturation and no flag.

## Configuration
- `FOO_PIPE_DATA_RESET_EN` defined:
  - Every `d[k]` is also asynchronously reset to 0.
  - `out` reads 0 from reset until the first valid result arrives.
- Not defined:
  - `d[k]` has no reset, which saves area. `out` is undefined until the first result.
  - The bench must ignore `out` whenever `output_valid = 0`.
- Valid and handshake behaviour are identical in both builds.

## Structure
- Package `foo_pipe_pkg` holds:
  - default `WIDTH`/`STAGES` localparams;
  - a function `stage_inc(k)` returning `WIDTH`'(1) << k;
  - an elaboration-time range check on `STAGES`.
- Sub-module `foo_pipe_stage`, parametrised by `WIDTH` and `K`:
  - combinational `f_K`;
  - the `v`/`d` registers;
  - `adv` input, `adv_prev` output.
- Top level: a generate loop of `STAGES` instances plus the output assigns.

## Test plan
- `WIDTH`=32, `STAGES`=2, `x`=5 accepted at cycle 0 with `output_ready`=1 → `out`=8 with `output_valid`=1 at cycle 2, for one cycle only.
- Wrap: `x`=0xFFFF_FFFE → `out`=0x0000_0001.
- `STAGES`=4, `x`=0 → `out`=15 after 4 cycles; `STAGES`=1, `x`=0x7 → `out`=0x8 after 1 cycle.
- Backpressure, `STAGES`=2:
  - stimulus: feed 1,2,3,4 back-to-back, hold `output_ready`=0 for cycles 1–5, then raise it;
  - required response: `input_ready` falls once 2 are held; outputs are 4,5,6,7 in order; `out` is stable while stalled.
- Bubble collapse:
  - stimulus: inputs at cycles 0 and 2, `output_ready`=0 at cycle 2 only;
  - required response: the second transaction advances into the empty stage; no loss.
- Mid-operation reset:
  - stimulus: assert `rst` with 2 transactions in flight;
  - required response: `output_valid` goes to 0 asynchronously and no stale result ever appears; with the macro defined, `out`=0.

Source files
------------

// File: rtl/foo_pipe_pkg.sv
// foo_pipe_pkg: shared definitions for the foo_pipe arithmetic pipeline.
//   DEFAULT_WIDTH / DEFAULT_STAGES : default operand width and pipeline depth.
//   stage_inc(k)                   : the constant added by stage k (1 << k).
//   stages_ok(width, stages)       : legality of a WIDTH/STAGES pair, used by
//                                    the top level as an elaboration check.
package foo_pipe_pkg;

  localparam int DEFAULT_WIDTH  = 32;
  localparam int DEFAULT_STAGES = 2;

  // Increment applied by stage k, at the default width.
  function automatic logic [DEFAULT_WIDTH-1:0] stage_inc(input int unsigned k);
    return DEFAULT_WIDTH'(1) << k;
  endfunction

  // A stage k adds 1 << k, so k must stay below WIDTH for the add to touch
  // any bit; hence STAGES may not exceed WIDTH.
  function automatic bit stages_ok(input int width, input int stages);
    return (width >= 2) && (stages >= 1) && (stages <= width);
  endfunction

endpackage

// File: rtl/foo_pipe_if.sv
// foo_pipe_if: ready/valid handshake bundle around foo_pipe.
//   x, input_valid, input_ready     : producer side (x sampled on valid & ready)
//   out, output_valid, output_ready : consumer side
// Modports:
//   master : the environment (drives x/input_valid/output_ready)
//   slave  : the pipeline (drives input_ready/out/output_valid)
interface foo_pipe_if
  import foo_pipe_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic [WIDTH-1:0] x;
  logic             input_valid;
  logic             input_ready;
  logic [WIDTH-1:0] out;
  logic             output_valid;
  logic             output_ready;

  modport master (
    output x, input_valid, output_ready,
    input  input_ready, out, output_valid
  );

  modport slave (
    input  x, input_valid, output_ready,
    output input_ready, out, output_valid
  );

endinterface

// File: rtl/foo_pipe_stage.sv
// foo_pipe_stage: one register stage of foo_pipe.
// Computes f_K(y) = y + (1 << K) mod 2^WIDTH on the incoming data and holds a
// valid bit plus a data register.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   adv         : the stage downstream can take a new value this cycle
//   adv_prev    : this stage advances this cycle (fed to the stage upstream)
//   prev_valid  : valid bit arriving from upstream (or the producer)
//   prev_data   : data arriving from upstream (or the producer)
//   v, d        : this stage's valid bit and data register
// Build option: FOO_PIPE_DATA_RESET_EN also clears d on reset.
module foo_pipe_stage
  import foo_pipe_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int K     = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             adv,
  output logic             adv_prev,
  input  logic             prev_valid,
  input  logic [WIDTH-1:0] prev_data,
  output logic             v,
  output logic [WIDTH-1:0] d
);

  logic [WIDTH-1:0] f_y;
  logic             advance;

  // Adding 1 << K leaves bits below K untouched, so only the upper slice
  // needs an adder; its carry-out is dropped, giving the mod 2^WIDTH wrap.
  if (K == 0) begin : g_inc_low
    assign f_y = prev_data + WIDTH'(1);
  end else begin : g_inc_slice
    logic [WIDTH-K-1:0] hi;
    assign hi  = prev_data[WIDTH-1:K] + (WIDTH-K)'(1);
    assign f_y = {hi, prev_data[K-1:0]};
  end

  // An empty stage always advances, which is what collapses bubbles while a
  // later stage is stalled.
  assign advance  = adv | ~v;
  assign adv_prev = advance;

  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples its upstream neighbour's pre-edge value, never a same-edge update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v <= 1'b0;
    end else if (advance) begin
      v <= prev_valid;
    end
  end

  // A bubble never overwrites data: d only loads when a valid value arrives.
`ifdef FOO_PIPE_DATA_RESET_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d <= '0;
    end else if (advance && prev_valid) begin
      d <= f_y;
    end
  end
`else
  // NOTE: the data path is deliberately left without reset; v alone says
  // whether d is meaningful, so clearing d would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (advance && prev_valid) begin
      d <= f_y;
    end
  end
`endif

endmodule

// File: rtl/foo_pipe.sv
// foo_pipe: STAGES-deep ready/valid arithmetic pipeline. Stage k adds 1 << k,
// so a result is x + (2^STAGES - 1) mod 2^WIDTH, STAGES cycles after it is
// accepted when there is no backpressure.
// Ports:
//   clk  : clock
//   rst  : asynchronous active-high reset (clears all valid bits)
//   bus  : foo_pipe_if slave modport (x/input_valid/input_ready,
//          out/output_valid/output_ready); its WIDTH must match this WIDTH
// Build option: FOO_PIPE_DATA_RESET_EN also resets the data registers, so
// out reads 0 until the first result.
module foo_pipe
  import foo_pipe_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int STAGES = DEFAULT_STAGES
) (
  input  logic          clk,
  input  logic          rst,
  foo_pipe_if.slave     bus
);

  if (!stages_ok(WIDTH, STAGES)) begin : g_bad_params
    $error("foo_pipe: need WIDTH >= 2 and 1 <= STAGES <= WIDTH");
  end

  // adv[k] is stage k's advance; adv[STAGES] is the consumer accepting.
  logic [STAGES:0]  adv;
  logic [STAGES-1:0] v;
  logic [WIDTH-1:0] d [STAGES];

  assign adv[STAGES] = bus.output_ready;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic             up_valid;
    logic [WIDTH-1:0] up_data;

    if (k == 0) begin : g_head
      assign up_valid = bus.input_valid;
      assign up_data  = bus.x;
    end else begin : g_body
      assign up_valid = v[k-1];
      assign up_data  = d[k-1];
    end

    foo_pipe_stage #(
      .WIDTH (WIDTH),
      .K     (k)
    ) u_stage (
      .clk        (clk),
      .rst        (rst),
      .adv        (adv[k+1]),
      .adv_prev   (adv[k]),
      .prev_valid (up_valid),
      .prev_data  (up_data),
      .v          (v[k]),
      .d          (d[k])
    );
  end

  // input_ready is the only combinational path from an input (output_ready)
  // to an output; out and output_valid come straight from registers.
  assign bus.input_ready  = adv[0];
  assign bus.out          = d[STAGES-1];
  assign bus.output_valid = v[STAGES-1];

endmodule
